// File: rtl/ahb_cmd_master.sv
// Command-driven AHB-Lite master: single/INCR word bursts with pipelined address/data phases.
// Define AHB_CMD_MASTER_ERR_ABORT_EN to cancel the rest of a burst when a beat returns ERROR.
module ahb_cmd_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 5
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_last,
  output logic [1:0]        htrans,
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hreadyout,
  input  logic [1:0]        hresp,
  input  logic [DATA_W-1:0] hrdata
);

`ifdef AHB_CMD_MASTER_ERR_ABORT_EN
  localparam bit ERR_ABORT = 1'b1;
`else
  localparam bit ERR_ABORT = 1'b0;
`endif

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam logic [1:0] HR_OKAY   = 2'b00;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_PIPE, S_LAST} state_t;

  state_t            state, state_nxt;
  logic [1:0]        htrans_nxt;
  logic [ADDR_W-1:0] haddr_nxt;
  logic [ADDR_W-1:0] addr_inc;
  logic              hwrite_nxt;
  logic [DATA_W-1:0] hwdata_nxt;
  logic [LEN_W-1:0]  addr_left, addr_left_nxt;
  logic [LEN_W-1:0]  rsp_left, rsp_left_nxt;
  logic [LEN_W-1:0]  len_eff;
  logic              aborted, aborted_nxt;
  logic              rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;
  logic              rsp_err_nxt;
  logic              rsp_last_nxt;
  logic              addr_acc;
  logic              data_phase;
  logic              data_done;
  logic              bus_err;

  assign addr_acc   = htrans[1] && hreadyout;
  assign data_phase = (state == S_PIPE) || (state == S_LAST);
  assign data_done  = data_phase && hreadyout;
  assign bus_err    = (hresp != HR_OKAY);
  assign addr_inc   = haddr + ADDR_W'(4);
  assign len_eff    = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
  assign cmd_ready  = (state == S_IDLE);
  // wr_data is consumed on the same edge that accepts the write address phase
  assign wr_pop     = addr_acc && hwrite;

  always_comb begin
    state_nxt     = state;
    htrans_nxt    = htrans;
    haddr_nxt     = haddr;
    hwrite_nxt    = hwrite;
    hwdata_nxt    = hwdata;
    addr_left_nxt = addr_left;
    rsp_left_nxt  = rsp_left;
    aborted_nxt   = aborted;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = 1'b0;
    rsp_last_nxt  = 1'b0;

    if (state == S_IDLE) begin
      if (cmd_valid) begin
        htrans_nxt    = HT_NONSEQ;
        haddr_nxt     = {cmd_addr[ADDR_W-1:2], 2'b00};
        hwrite_nxt    = cmd_write;
        addr_left_nxt = len_eff - LEN_W'(1);
        rsp_left_nxt  = len_eff;
        aborted_nxt   = 1'b0;
        state_nxt     = S_ADDR;
      end
    end else begin
      if (data_done) begin
        rsp_valid_nxt = 1'b1;
        rsp_rdata_nxt = hwrite ? '0 : hrdata;
        rsp_err_nxt   = bus_err;
        rsp_last_nxt  = (rsp_left == LEN_W'(1)) || aborted;
        rsp_left_nxt  = rsp_left - LEN_W'(1);
      end

      if (addr_acc) begin
        if (hwrite) begin
          hwdata_nxt = wr_data;
        end
        if (addr_left != '0) begin
          // a new 1 KB page must restart with NONSEQ
          htrans_nxt    = (addr_inc[9:0] == 10'd0) ? HT_NONSEQ : HT_SEQ;
          haddr_nxt     = addr_inc;
          addr_left_nxt = addr_left - LEN_W'(1);
          state_nxt     = S_PIPE;
        end else begin
          htrans_nxt = HT_IDLE;
          state_nxt  = S_LAST;
        end
      end else if (ERR_ABORT && (state == S_PIPE) && bus_err) begin
        // first ERROR cycle: withdraw the pending address phase
        htrans_nxt    = HT_IDLE;
        addr_left_nxt = '0;
        aborted_nxt   = 1'b1;
        state_nxt     = S_LAST;
      end

      if ((state == S_LAST) && data_done) begin
        state_nxt   = S_IDLE;
        aborted_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state     <= S_IDLE;
      htrans    <= HT_IDLE;
      haddr     <= '0;
      hwrite    <= 1'b0;
      hwdata    <= '0;
      addr_left <= '0;
      rsp_left  <= '0;
      aborted   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      htrans    <= htrans_nxt;
      haddr     <= haddr_nxt;
      hwrite    <= hwrite_nxt;
      hwdata    <= hwdata_nxt;
      addr_left <= addr_left_nxt;
      rsp_left  <= rsp_left_nxt;
      aborted   <= aborted_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_last  <= rsp_last_nxt;
    end
  end

endmodule
